wide_add_sub_seq: RTL and testbench
===================================

Name: wide_add_sub_seq

Overview:
Multi-precision add/subtract sequencer that sits on the operand side of the post-adder/subtractor.
- Accepts one wide operand pair of NCHUNK*WIDTH bits over a valid/ready handshake.
- Slices the pair into WIDTH-bit chunks, least-significant first, and drives them into the post-adder's X/Z/CIN/select inputs.
- Captures each P/CARRYOUT result and chains CARRYOUT into the next chunk's CIN.
- Returns the assembled wide result and the final carry/borrow over a second valid/ready handshake.

Parameters:
- WIDTH, 48, chunk width; equals post-adder WIDTH.
- NCHUNK, 2, number of chunks per operand; must be ≥ 1.
- PA_LAT, 1, cycles from operands driven to pa_out/pa_cout valid. Default matches the downstream instance built with REG_OUT=1, REG_COUT=1, REG_CIN=0. Must be ≥ 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- s_valid  in  1  request valid.
- s_ready  out  1  block idle and able to accept a request.
- s_op  in  1  0 = A+B, 1 = A−B.
- s_a  in  NCHUNK*WIDTH  operand A; drives Z.
- s_b  in  NCHUNK*WIDTH  operand B; drives X.
- pa_z  out  WIDTH  current A chunk, to post-adder mux_Z_in1.
- pa_x  out  WIDTH  current B chunk, to post-adder mux_X_in1.
- pa_z_sel  out  2  2'b01 while busy, 2'b00 otherwise.
- pa_x_sel  out  2  2'b01 while busy, 2'b00 otherwise.
- pa_sel  out  1  add/subtract select, equals latched op.
- pa_cin  out  1  chained carry/borrow.
- pa_ce  out  1  clock enable for carry and P registers; 1 while busy.
- pa_out  in  WIDTH  post-adder result.
- pa_cout  in  1  post-adder carry/borrow out.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_result  out  NCHUNK*WIDTH  assembled result.
- m_carry  out  1  final carry (add) or borrow (sub).

Behaviour:
- Reset (rst_n=0, async): state IDLE, chunk index 0, carry 0.
  - All outputs 0 except s_ready, which is 1 once rst_n is released.
  - Reset mid-operation aborts the transaction; no m_valid follows.
- States and transitions:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch s_a, s_b and s_op, set idx=0 and carry=0, go to ISSUE.
  - ISSUE: drive chunk idx.
    - pa_z = A[idx*WIDTH +: WIDTH], pa_x = B[idx*WIDTH +: WIDTH], pa_cin = carry, pa_sel = op, pa_ce = 1.
    - If PA_LAT == 0, go to CAPTURE; otherwise go to WAIT with wait counter = PA_LAT−1.
  - WAIT: hold all pa_* outputs stable. Decrement the counter; go to CAPTURE when it reaches 0.
  - CAPTURE: operands still held.
    - Sample pa_out into m_result[idx*WIDTH +: WIDTH] and pa_cout into carry.
    - If idx == NCHUNK−1, go to DONE; otherwise idx++ and go to ISSUE.
  - DONE: m_valid=1, m_carry=carry, pa_ce=0, sel outputs 2'b00, s_ready=0. m_result is held stable. On m_ready, go to IDLE.
- Carry semantics: the post-adder computes Z+X+cin or Z−(X+cin), and its cout is bit WIDTH of that result.
  - Subtract: cout=1 means borrow; feeding it back as the next cin subtracts the borrow.
  - The same chaining rule therefore serves both operations.
  - Chunk 0 cin = 0, unless the optional feature below is enabled.
- Latency: accept at cycle 0 → m_valid first high at cycle NCHUNK*(PA_LAT+2) (ISSUE + PA_LAT WAIT + CAPTURE per chunk). Defaults give cycle 6.
- No overlap: s_ready=0 from acceptance until the DONE handshake completes. s_valid in DONE is ignored.
- Inputs s_a/s_b may change after acceptance without effect.
- m_valid held with m_ready=0: m_result and m_carry stay stable indefinitely.
- NCHUNK=1: a single ISSUE/CAPTURE pass.

Optional Feature:
WADS_CARRY_IN_EN
- Defined: adds input port s_cin (1 bit), latched at acceptance and used as the chunk-0 cin. This gives A+B+s_cin, or A−B−s_cin for subtraction.
- Undefined: the port is absent and chunk-0 cin = 0.

Decomposition:
- Shared package wads_pkg:
  - State enum (IDLE, ISSUE, WAIT, CAPTURE, DONE).
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - MUX_SEL_IN1=2'b01, MUX_SEL_ZERO=2'b00.
- One sub-module, wads_chunk_ctr: chunk index plus PA_LAT wait counter, with last_chunk and wait_done flags.

Test Plan (defaults unless stated; the bench instantiates the post-adder with matching registers):
- Add with carry across chunks: A = {48'h0, 48'hFFFF_FFFF_FFFF}, B = 96'h1 → m_result = {48'h1, 48'h0}, m_carry = 0, m_valid at cycle 6.
- Subtract with borrow across chunks: A = {48'h1, 48'h0}, B = 96'h1 → m_result = {48'h0, 48'hFFFF_FFFF_FFFF}, m_carry = 0.
- Underflow and overflow:
  - Sub A=0, B=1 → all-ones result, m_carry = 1.
  - Add A=all-ones, B=1 → m_result = 0, m_carry = 1.
- Backpressure: hold m_ready=0 for 3 cycles in DONE → m_result stable, s_ready = 0, a second s_valid is not accepted. Release → IDLE, s_ready = 1.
- Reset mid-operation: drop rst_n during WAIT of chunk 1 → immediately m_valid = 0 and pa_ce = 0. After release s_ready = 1, and the next request completes correctly.
- PA_LAT=0, NCHUNK=3 with WADS_CARRY_IN_EN defined: add 1+1 with s_cin = 1 → m_result = 3, m_valid at cycle 6.

Source files
------------

// File: rtl/wide_add_sub_seq_pkg.sv
// wads_pkg: shared types and constants for the wide add/subtract sequencer.
//   wads_state_e  sequencer states
//   OP_ADD/OP_SUB operation encoding on s_op / pa_sel
//   MUX_SEL_*     post-adder X/Z mux selections
//   clog2_min1    index width helper that never returns 0
package wads_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } wads_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic [1:0] MUX_SEL_IN1  = 2'b01;
   localparam logic [1:0] MUX_SEL_ZERO = 2'b00;

   // Counters sized for n values still need at least one bit when n <= 1.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sub_seq_chunk_ctr.sv
// wads_chunk_ctr: chunk index and post-adder latency counter.
//   clk, rst_n    clock, async active-low reset
//   clr_i         restart at chunk 0 (new request)
//   adv_i         move to the next chunk
//   load_i        start a latency wait (loads PA_LAT-1)
//   dec_i         count one wait cycle down
//   idx_o         current chunk index
//   last_chunk_o  idx_o is the most-significant chunk
//   wait_done_o   wait counter has reached 0
module wads_chunk_ctr
   import wads_pkg::*;
#(
   parameter int NCHUNK = 2,
   parameter int PA_LAT = 1,
   localparam int IDXW = clog2_min1(NCHUNK),
   localparam int WCW  = clog2_min1(PA_LAT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            adv_i,
   input  logic            load_i,
   input  logic            dec_i,
   output logic [IDXW-1:0] idx_o,
   output logic            last_chunk_o,
   output logic            wait_done_o
);

   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);
   // With PA_LAT == 0 the wait state is never entered; the load value is moot.
   localparam logic [WCW-1:0]  WLOAD    = (PA_LAT > 0) ? WCW'(PA_LAT - 1) : '0;

   logic [IDXW-1:0] idx_q, idx_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         wcnt_q <= '0;
      end else begin
         idx_q  <= idx_d;
         wcnt_q <= wcnt_d;
      end
   end

   always_comb begin
      idx_d  = idx_q;
      wcnt_d = wcnt_q;
      if (clr_i)
         idx_d = '0;
      else if (adv_i)
         idx_d = idx_q + IDXW'(1);
      if (load_i)
         wcnt_d = WLOAD;
      else if (dec_i && (wcnt_q != '0))
         wcnt_d = wcnt_q - WCW'(1);
   end

   assign idx_o        = idx_q;
   assign last_chunk_o = (idx_q == IDX_LAST);
   assign wait_done_o  = (wcnt_q == '0);

endmodule

// File: rtl/wide_add_sub_seq.sv
// wide_add_sub_seq: multi-precision add/subtract sequencer feeding a
// WIDTH-bit post-adder one chunk at a time, least-significant chunk first,
// chaining the post-adder carry/borrow into the next chunk's carry-in.
//   clk, rst_n                      clock, async active-low reset
//   s_valid/s_ready/s_op/s_a/s_b    request (A drives Z, B drives X)
//   s_cin                           chunk-0 carry-in (WADS_CARRY_IN_EN only)
//   pa_z/pa_x/pa_z_sel/pa_x_sel     post-adder operands and mux selects
//   pa_sel/pa_cin/pa_ce             add/sub select, carry-in, clock enable
//   pa_out/pa_cout                  post-adder result and carry/borrow out
//   m_valid/m_ready/m_result/m_carry  response
// Optional feature macro: WADS_CARRY_IN_EN adds s_cin; otherwise chunk 0
// starts with carry-in 0.
module wide_add_sub_seq
   import wads_pkg::*;
#(
   parameter int WIDTH  = 48,
   parameter int NCHUNK = 2,
   parameter int PA_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    s_op,
   input  logic [NCHUNK*WIDTH-1:0] s_a,
   input  logic [NCHUNK*WIDTH-1:0] s_b,
`ifdef WADS_CARRY_IN_EN
   input  logic                    s_cin,
`endif
   output logic [WIDTH-1:0]        pa_z,
   output logic [WIDTH-1:0]        pa_x,
   output logic [1:0]              pa_z_sel,
   output logic [1:0]              pa_x_sel,
   output logic                    pa_sel,
   output logic                    pa_cin,
   output logic                    pa_ce,
   input  logic [WIDTH-1:0]        pa_out,
   input  logic                    pa_cout,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [NCHUNK*WIDTH-1:0] m_result,
   output logic                    m_carry
);

   localparam int IDXW = clog2_min1(NCHUNK);

   wads_state_e state_q, state_d;

   logic [NCHUNK-1:0][WIDTH-1:0] a_q, b_q, res_q;
   logic                         op_q, carry_q;
   logic                         cin0, busy, accept;

   logic            ctr_clr, ctr_adv, ctr_load, ctr_dec;
   logic [IDXW-1:0] idx;
   logic            last_chunk, wait_done;

`ifdef WADS_CARRY_IN_EN
   assign cin0 = s_cin;
`else
   assign cin0 = 1'b0;
`endif

   wads_chunk_ctr #(
      .NCHUNK (NCHUNK),
      .PA_LAT (PA_LAT)
   ) u_ctr (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (ctr_clr),
      .adv_i        (ctr_adv),
      .load_i       (ctr_load),
      .dec_i        (ctr_dec),
      .idx_o        (idx),
      .last_chunk_o (last_chunk),
      .wait_done_o  (wait_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ctr_clr  = 1'b0;
      ctr_adv  = 1'b0;
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      unique case (state_q)
         IDLE: if (s_valid) begin
            state_d = ISSUE;
            ctr_clr = 1'b1;
         end
         ISSUE: if (PA_LAT == 0) begin
            state_d = CAPTURE;
         end else begin
            state_d  = WAIT;
            ctr_load = 1'b1;
         end
         // Counter holds the remaining wait cycles after this one.
         WAIT: if (wait_done) state_d = CAPTURE;
               else           ctr_dec = 1'b1;
         CAPTURE: if (last_chunk) begin
            state_d = DONE;
         end else begin
            state_d = ISSUE;
            ctr_adv = 1'b1;
         end
         DONE: if (m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign accept = (state_q == IDLE) && s_valid;

   // Operands are snapshotted on acceptance so the requester may move on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         carry_q <= 1'b0;
         res_q   <= '0;
      end else begin
         if (accept) begin
            a_q     <= s_a;
            b_q     <= s_b;
            op_q    <= s_op;
            carry_q <= cin0;
         end
         // Borrow out of a subtract chunk is exactly the next chunk's cin,
         // so add and subtract share this chaining path.
         if (state_q == CAPTURE) begin
            res_q[idx] <= pa_out;
            carry_q    <= pa_cout;
         end
      end
   end

   assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CAPTURE);

   // Gated by rst_n so ready is low while reset is asserted.
   assign s_ready  = rst_n && (state_q == IDLE);

   assign pa_z     = busy ? a_q[idx] : '0;
   assign pa_x     = busy ? b_q[idx] : '0;
   assign pa_z_sel = busy ? MUX_SEL_IN1 : MUX_SEL_ZERO;
   assign pa_x_sel = busy ? MUX_SEL_IN1 : MUX_SEL_ZERO;
   assign pa_sel   = op_q;
   assign pa_cin   = busy & carry_q;
   assign pa_ce    = busy;

   assign m_valid  = (state_q == DONE);
   assign m_carry  = (state_q == DONE) & carry_q;
   assign m_result = res_q;

endmodule

// File: tb/tb_wide_add_sub_seq.sv
module tb_wide_add_sub_seq;

`ifdef WADS_CARRY_IN_EN
   localparam bit HAS_CIN = 1'b1;
`else
   localparam bit HAS_CIN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   // ---------------- DUT 1: defaults (WIDTH 48, NCHUNK 2, PA_LAT 1) -------
   logic        s_valid, s_ready, s_op, s_cin;
   logic [95:0] s_a, s_b;
   logic [47:0] pa_z, pa_x, pa_out;
   logic [1:0]  pa_z_sel, pa_x_sel;
   logic        pa_sel, pa_cin, pa_ce, pa_cout;
   logic        m_valid, m_ready, m_carry;
   logic [95:0] m_result;

   wide_add_sub_seq u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b),
`ifdef WADS_CARRY_IN_EN
      .s_cin(s_cin),
`endif
      .pa_z(pa_z), .pa_x(pa_x), .pa_z_sel(pa_z_sel), .pa_x_sel(pa_x_sel),
      .pa_sel(pa_sel), .pa_cin(pa_cin), .pa_ce(pa_ce),
      .pa_out(pa_out), .pa_cout(pa_cout),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_carry(m_carry)
   );

   // Post-adder with registered P and CARRYOUT, unregistered CIN.
   always_ff @(posedge clk)
      if (pa_ce)
         {pa_cout, pa_out} <= (pa_sel == wads_pkg::OP_SUB) ?
            ({1'b0, pa_z} - {1'b0, pa_x} - 49'(pa_cin)) :
            ({1'b0, pa_z} + {1'b0, pa_x} + 49'(pa_cin));

   // ---------------- DUT 2: NCHUNK 3, PA_LAT 0 ----------------------------
   logic         s_valid2, s_ready2, s_op2, s_cin2;
   logic [143:0] s_a2, s_b2;
   logic [47:0]  pa_z2, pa_x2, pa_out2;
   logic [1:0]   pa_z_sel2, pa_x_sel2;
   logic         pa_sel2, pa_cin2, pa_ce2, pa_cout2;
   logic         m_valid2, m_ready2, m_carry2;
   logic [143:0] m_result2;

   wide_add_sub_seq #(.WIDTH(48), .NCHUNK(3), .PA_LAT(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid2), .s_ready(s_ready2), .s_op(s_op2), .s_a(s_a2), .s_b(s_b2),
`ifdef WADS_CARRY_IN_EN
      .s_cin(s_cin2),
`endif
      .pa_z(pa_z2), .pa_x(pa_x2), .pa_z_sel(pa_z_sel2), .pa_x_sel(pa_x_sel2),
      .pa_sel(pa_sel2), .pa_cin(pa_cin2), .pa_ce(pa_ce2),
      .pa_out(pa_out2), .pa_cout(pa_cout2),
      .m_valid(m_valid2), .m_ready(m_ready2), .m_result(m_result2), .m_carry(m_carry2)
   );

   // Fully combinational post-adder.
   assign {pa_cout2, pa_out2} = (pa_sel2 == wads_pkg::OP_SUB) ?
      ({1'b0, pa_z2} - {1'b0, pa_x2} - 49'(pa_cin2)) :
      ({1'b0, pa_z2} + {1'b0, pa_x2} + 49'(pa_cin2));

   // ---------------- reference model and checkers -------------------------
   // Whole-operand arithmetic one bit wider than the operand width in use:
   // bit [w] of the answer is the carry (add) or the borrow (sub).
   function automatic logic [144:0] ref_calc(input logic op, input logic [143:0] a,
                                             input logic [143:0] b, input logic cin);
      logic [144:0] aa, bb;
      aa = {1'b0, a};
      bb = {1'b0, b};
      if (op == wads_pkg::OP_SUB) return aa - bb - 145'(cin);
      return aa + bb + 145'(cin);
   endfunction

   task automatic chkw(input string nm, input logic [143:0] act, input logic [143:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chkw(nm, 144'(act), 144'(exp));
   endtask

   function automatic logic [143:0] rnd_op();
      logic [159:0] v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return 144'($urandom_range(0, 3));
         3:       return {v[143:48], 48'hFFFF_FFFF_FFFF};
         default: return v[143:0];
      endcase
   endfunction

   // Scoreboard for DUT 1: one expectation per accepted request.
   typedef struct {
      logic [95:0] r;
      logic        c;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   bit   busy1 = 1'b0;
   bit   seen1 = 1'b0;

   always @(negedge clk) begin
      logic [144:0] e;
      exp_t         x;
      if (!rst_n) begin
         exp_q.delete();
         busy1 = 1'b0;
         seen1 = 1'b0;
         chk1("rst_m_valid", m_valid, 1'b0);
         chk1("rst_pa_ce", pa_ce, 1'b0);
      end else begin
         chk1("s_ready", s_ready, !busy1);
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               chk1("spurious_m_valid", m_valid, 1'b0);
            end else begin
               if (!seen1) begin
                  chkw("latency", 144'(cyc - exp_q[0].acc), 144'(6));
                  seen1 = 1'b1;
               end
               chkw("m_result", 144'(m_result), 144'(exp_q[0].r));
               chk1("m_carry", m_carry, exp_q[0].c);
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  busy1 = 1'b0;
                  seen1 = 1'b0;
               end
            end
         end else if (seen1) begin
            chk1("m_valid_dropped", m_valid, 1'b1);
         end
         if (s_valid && s_ready) begin
            e     = ref_calc(s_op, 144'(s_a), 144'(s_b), s_cin & HAS_CIN);
            x.r   = e[95:0];
            x.c   = e[96];
            x.acc = cyc + 1;
            exp_q.push_back(x);
            busy1 = 1'b1;
         end
      end
   end

   // ---------------- driver tasks (called at posedge + #1) ----------------
   task automatic send(input logic op, input logic [95:0] a, input logic [95:0] b,
                       input logic cin);
      int t;
      s_valid = 1'b1; s_op = op; s_a = a; s_b = b; s_cin = cin;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready && t < 40);
      chk1("send_ready", s_ready, 1'b1);
      @(posedge clk); #1;
      // Scramble the request lines: the sequencer must use its snapshot.
      s_valid = 1'b0;
      s_a     = {$urandom, $urandom, $urandom};
      s_b     = ~s_b;
      s_cin   = ~cin;
   endtask

   task automatic recv(input int hold, output logic [95:0] r, output logic c);
      int t;
      m_ready = (hold == 0);
      t = 0;
      do begin @(negedge clk); t++; end while (!m_valid && t < 40);
      chk1("recv_valid", m_valid, 1'b1);
      r = m_result;
      c = m_carry;
      if (hold > 0) begin
         @(posedge clk); #1;
         // A second request during backpressure must not be taken.
         s_valid = 1'b1; s_op = ~s_op; s_a = ~s_a; s_b = s_b + 96'd3;
         repeat (hold - 1) @(posedge clk);
         #1 m_ready = 1'b1; s_valid = 1'b0;
      end
      @(posedge clk); #1 m_ready = 1'b0;
   endtask

   task automatic run2(input logic op, input logic [143:0] a, input logic [143:0] b,
                       input logic cin, output logic [143:0] r);
      logic [144:0] e;
      int           t, acc;
      s_valid2 = 1'b1; s_op2 = op; s_a2 = a; s_b2 = b; s_cin2 = cin; m_ready2 = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready2 && t < 40);
      chk1("d2_ready", s_ready2, 1'b1);
      acc = cyc + 1;
      @(posedge clk); #1;
      s_valid2 = 1'b0; s_a2 = ~a; s_b2 = ~b; s_cin2 = ~cin;
      t = 0;
      do begin @(negedge clk); t++; end while (!m_valid2 && t < 40);
      chk1("d2_valid", m_valid2, 1'b1);
      e = ref_calc(op, a, b, cin & HAS_CIN);
      chkw("d2_latency", 144'(cyc - acc), 144'(6));
      chkw("d2_result", m_result2, e[143:0]);
      chk1("d2_carry", m_carry2, e[144]);
      r = m_result2;
      @(posedge clk); #1 m_ready2 = 1'b0;
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      logic [95:0]  r, a, b;
      logic [143:0] r2, a2, b2, tmp;
      logic         c;

      rst_n = 1'b0;
      s_valid = 1'b0; s_op = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; m_ready = 1'b0;
      s_valid2 = 1'b0; s_op2 = 1'b0; s_a2 = '0; s_b2 = '0; s_cin2 = 1'b0; m_ready2 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chkw("rst_m_result", 144'(m_result), 144'(0));
      chk1("rst_m_carry", m_carry, 1'b0);
      chkw("rst_pa_z", 144'(pa_z), 144'(0));
      chkw("rst_pa_z_sel", 144'(pa_z_sel), 144'(0));
      chk1("rst_s_ready_low", s_ready, 1'b0);
      rst_n = 1'b1;
      #1;
      chk1("rst_s_ready", s_ready, 1'b1);
      chk1("rst_s_ready2", s_ready2, 1'b1);
      @(posedge clk); #1;

      // Carry out of chunk 0 into chunk 1.
      send(wads_pkg::OP_ADD, {48'h0, 48'hFFFF_FFFF_FFFF}, 96'h1, 1'b0);
      recv(0, r, c);
      chkw("add_carry_chain", 144'(r), 144'({48'h1, 48'h0}));
      chk1("add_carry_chain_c", c, 1'b0);

      // Borrow out of chunk 0 into chunk 1.
      send(wads_pkg::OP_SUB, {48'h1, 48'h0}, 96'h1, 1'b0);
      recv(0, r, c);
      chkw("sub_borrow_chain", 144'(r), 144'({48'h0, 48'hFFFF_FFFF_FFFF}));
      chk1("sub_borrow_chain_c", c, 1'b0);

      // Underflow and overflow.
      send(wads_pkg::OP_SUB, 96'h0, 96'h1, 1'b0);
      recv(0, r, c);
      chkw("sub_underflow", 144'(r), 144'({96{1'b1}}));
      chk1("sub_underflow_c", c, 1'b1);

      send(wads_pkg::OP_ADD, {96{1'b1}}, 96'h1, 1'b0);
      recv(0, r, c);
      chkw("add_overflow", 144'(r), 144'(0));
      chk1("add_overflow_c", c, 1'b1);

      // Backpressure: three cycles of m_ready low in DONE.
      send(wads_pkg::OP_ADD, 96'h5, 96'h7, 1'b0);
      recv(3, r, c);
      chkw("bp_result", 144'(r), 144'(96'hC));
      chk1("bp_s_ready_after", s_ready, 1'b1);

      // Reset during the wait cycle of chunk 1 aborts the request.
      send(wads_pkg::OP_ADD, 96'h123, 96'h456, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk1("pre_rst_pa_ce", pa_ce, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_m_valid", m_valid, 1'b0);
      chk1("mid_rst_pa_ce", pa_ce, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk1("post_rst_s_ready", s_ready, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      send(wads_pkg::OP_SUB, 96'h1000, 96'h1, 1'b0);
      recv(0, r, c);
      chkw("post_rst_result", 144'(r), 144'(96'hFFF));
      chk1("post_rst_c", c, 1'b0);

      // Three-chunk, zero-latency instance: 1 + 1 (+ s_cin when present).
      run2(wads_pkg::OP_ADD, 144'd1, 144'd1, 1'b1, r2);
      chkw("d2_pin", r2, HAS_CIN ? 144'd3 : 144'd2);
      run2(wads_pkg::OP_SUB, 144'd0, 144'd1, 1'b0, r2);
      chkw("d2_pin_under", r2, {144{1'b1}});

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         tmp = rnd_op(); a = tmp[95:0];
         tmp = rnd_op(); b = tmp[95:0];
         send(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)));
         recv(int'($urandom_range(0, 2)), r, c);
      end
      for (int i = 0; i < 15; i++) begin
         a2 = rnd_op();
         b2 = rnd_op();
         run2(1'($urandom_range(0, 1)), a2, b2, 1'($urandom_range(0, 1)), r2);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
